mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

- Parametrised N-port memory arbiter that merges the CPU's independent memory ports onto one shared downstream memory/cache port.
- Ports include the instruction fetch port and the data port, plus any extra requesters (e.g. a prefetcher or debug port).
- Supports one outstanding transaction at a time, with fixed-priority or round-robin arbitration.
- Uses the same hold-until-resp handshake as the CPU ports on both the requester side and the memory side.

## Interface
Parameters:
- NUM_PORTS, 2, number of requester ports (≥2)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (multiple of 8)
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- port_read  in  NUM_PORTS  per-port read request
- port_write  in  NUM_PORTS  per-port write request
- port_wmask  in  NUM_PORTS×(DATA_WIDTH/8)  per-port byte enables
- port_address  in  NUM_PORTS×ADDR_WIDTH  per-port address
- port_wdata  in  NUM_PORTS×DATA_WIDTH  per-port write data
- port_resp  out  NUM_PORTS  one-hot completion pulse
- port_rdata  out  DATA_WIDTH  read data, shared; valid only with the matching port_resp bit
- mem_read  out  1  downstream read request
- mem_write  out  1  downstream write request
- mem_wmask  out  DATA_WIDTH/8  downstream byte enables
- mem_address  out  ADDR_WIDTH  downstream address
- mem_wdata  out  DATA_WIDTH  downstream write data
- mem_resp  in  1  downstream completion pulse
- mem_rdata  in  DATA_WIDTH  downstream read data
- busy  out  1  high while in BUSY
- gnt_idx  out  clog2(NUM_PORTS)  registered index of the current or last grant

## Operation
- **Requester protocol:** a requester holds read or write high, with address, wmask and wdata stable, until it sees its port_resp bit. It may drop the request in the cycle after resp.
- **Read and write both high on one port:** treated as a write.
- **FSM states:** IDLE and BUSY.
- **IDLE:**
  - Request vector req[i] = port_read[i] | port_write[i].
  - If any bit of req is set, pick the winner, register it into gnt_idx, go to BUSY.
  - If req is all zero, stay in IDLE.
- **Fixed priority (RR_MODE=0):** winner is the lowest set index.
- **Round-robin (RR_MODE=1):**
  - Search starts at last_gnt+1 and wraps modulo NUM_PORTS.
  - last_gnt is updated to the winner on each grant.
- **BUSY, driving the memory side:** mem_* outputs are a combinational mux of port gnt_idx's signals, gated by the current state.
  - mem_write = port_write[gnt].
  - mem_read = port_read[gnt] & ~port_write[gnt].
- **BUSY, completing a transaction:**
  - When mem_resp=1: port_resp[gnt]=1 in the same cycle and port_rdata=mem_rdata (combinational pass-through); next state is IDLE.
  - The mandatory IDLE cycle lets the completed requester drop its request before re-arbitration. This prevents double issue.
- **Outside BUSY:**
  - All mem_read, mem_write and port_resp outputs are 0.
  - mem_resp is ignored; stray responses are dropped.
- **Reset values:**
  - state = IDLE; gnt_idx = 0; last_gnt = NUM_PORTS-1, so port 0 wins first.
  - mem_read, mem_write, port_resp and busy = 0.
  - mem_address, mem_wdata, mem_wmask and port_rdata are don't-care but must not be X: drive them from the port-0 or mem inputs.
- **Reset mid-transaction:** state returns to IDLE immediately and the downstream request drops. A mem_resp arriving after reset goes to no port.

## Timing
- **Request to memory:** request first high in cycle 0 with the arbiter in IDLE → mem_read or mem_write high in cycle 1.
- **Completion:** mem_resp in cycle k → port_resp in cycle k (zero added latency) → IDLE in cycle k+1 → next grant registered at the end of cycle k+1 → next downstream request in cycle k+2.
- **Minimum transaction period:** 2 cycles of arbiter overhead plus memory latency.
- **Simultaneous requests in IDLE:** exactly one grant. The losers stay pending with no response and remain eligible next time.
- **A request arriving while BUSY:** not sampled until the next IDLE cycle.
- **Starvation:** in round-robin mode, every continuously-requesting port is served within NUM_PORTS grants. Fixed-priority mode gives no starvation guarantee.

## Structure
- **Shared package:** add the arb_state_t enum (IDLE, BUSY) to the shared rv32i_types package, together with a localparam helper for the index width clog2(NUM_PORTS).
- **Sub-module rr_picker:** a combinational rotate-then-priority-encode block.
  - Inputs: req and last_gnt. Output: the winner index.
  - A mode input bypasses the rotation for fixed priority.
- **Top level:** holds the FSM, the gnt_idx and last_gnt registers, and the output muxes.

## Test plan
- Reset, then port 0 reads address 0x100 with memory latency 3 → mem_read high in cycle 1, port_resp=0b01 in cycle 4 with rdata=0xDEADBEEF, busy low in cycle 5.
- RR_MODE=1, NUM_PORTS=4, all ports requesting continuously → grant sequence 0,1,2,3,0. Each transaction spaced exactly 2+latency cycles apart.
- RR_MODE=0, ports 1 and 2 requesting continuously → port 1 granted every time; port 2 never receives resp.
- Port 1 write of 0xA5A5A5A5 to 0x200 with wmask=0b0011 while port 0 reads 0x300 simultaneously → port 0 is served first. Memory sees the write with mask 0b0011 exactly once. No duplicate transactions.
- rst asserted during BUSY, with mem_resp pulsed one cycle after rst deasserts → no port_resp bit asserts, state is IDLE, the next request is granted normally.
- Port asserts read and write together → only mem_write=1 is seen downstream.

Source files
------------

// File: rtl/rv32i_types.sv
// Types shared across the rv32i core; the memory-port arbiter FSM state and
// the helper that sizes its port-index registers live here.
package rv32i_types;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Width of an index into n ports, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational winner selection: rotate the request vector so the search
// starts just after the last grant, then take the lowest set position.
module rr_picker
  import rv32i_types::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_gnt,
  input  logic                 rr_mode,
  output logic                 valid,
  output logic [IDX_W-1:0]     winner
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);
  localparam logic [IDX_W:0]   PORTS_W  = (IDX_W + 1)'(NUM_PORTS);

  logic [IDX_W:0]       start;
  logic [IDX_W-1:0]     rot_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0] rot_req;

  // Fixed priority simply starts the search at port 0.
  always_comb begin
    start = '0;
    if (rr_mode && (last_gnt != LAST_IDX)) begin
      start = {1'b0, last_gnt} + (IDX_W + 1)'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rot
      localparam logic [IDX_W:0] OFS = (IDX_W + 1)'(gi);
      logic [IDX_W:0] sum;
      assign sum         = start + OFS;
      assign rot_idx[gi] = (sum >= PORTS_W) ? IDX_W'(sum - PORTS_W) : sum[IDX_W-1:0];
      assign rot_req[gi] = req[rot_idx[gi]];
    end
  endgenerate

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        valid  = 1'b1;
        winner = rot_idx[k];
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges N hold-until-resp requester ports onto one downstream memory port,
// one outstanding transaction at a time, round-robin or fixed priority.
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RR_MODE    = 1,
  localparam int IDX_W     = idx_width(NUM_PORTS),
  localparam int MASK_W    = DATA_WIDTH / 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            port_read,
  input  logic [NUM_PORTS-1:0]            port_write,
  input  logic [NUM_PORTS*MASK_W-1:0]     port_wmask,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata,
  output logic [NUM_PORTS-1:0]            port_resp,
  output logic [DATA_WIDTH-1:0]           port_rdata,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [MASK_W-1:0]               mem_wmask,
  output logic [ADDR_WIDTH-1:0]           mem_address,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic                            mem_resp,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  output logic                            busy,
  output logic [IDX_W-1:0]                gnt_idx
);

  arb_state_t state_reg, state_next;
  logic [IDX_W-1:0] gnt_reg;
  logic [IDX_W-1:0] last_gnt_reg;

  logic [NUM_PORTS-1:0]  req;
  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];
  logic [MASK_W-1:0]     wmask_arr [NUM_PORTS];
  logic                  sel_read;
  logic                  sel_write;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign addr_arr[gi]  = port_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = port_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign wmask_arr[gi] = port_wmask[gi*MASK_W +: MASK_W];
      assign req[gi]       = port_read[gi] | port_write[gi];
    end
  endgenerate

  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req      (req),
    .last_gnt (last_gnt_reg),
    .rr_mode  (RR_MODE != 0),
    .valid    (pick_valid),
    .winner   (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // last_gnt resets to the top port so the first round-robin search lands on port 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_reg      <= '0;
      last_gnt_reg <= IDX_W'(NUM_PORTS - 1);
    end else if ((state_reg == IDLE) && pick_valid) begin
      gnt_reg      <= pick_idx;
      last_gnt_reg <= pick_idx;
    end
  end

  // BUSY always returns through IDLE so the finished requester can drop its request.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pick_valid) state_next = BUSY;
      BUSY:    if (mem_resp) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Data-path muxes stay ungated so they always carry a defined port value.
  assign sel_read    = port_read[gnt_reg];
  assign sel_write   = port_write[gnt_reg];
  assign mem_address = addr_arr[gnt_reg];
  assign mem_wdata   = wdata_arr[gnt_reg];
  assign mem_wmask   = wmask_arr[gnt_reg];
  assign port_rdata  = mem_rdata;
  assign gnt_idx     = gnt_reg;

  always_comb begin
    busy      = (state_reg == BUSY);
    mem_write = busy & sel_write;
    mem_read  = busy & sel_read & ~sel_write;
    port_resp = '0;
    if (busy && mem_resp) begin
      port_resp[gnt_reg] = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with directed and random
// requester traffic and checks every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int ND = 2;

  localparam int RQ_OFF     = 0;
  localparam int RQ_ONESHOT = 1;
  localparam int RQ_CONT    = 2;
  localparam int RQ_RAND    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    p_read  [ND];
  logic [N-1:0]    p_write [ND];
  logic [N*MW-1:0] p_wmask [ND];
  logic [N*AW-1:0] p_addr  [ND];
  logic [N*DW-1:0] p_wdata [ND];
  logic [N-1:0]    p_resp  [ND];
  logic [DW-1:0]   p_rdata [ND];
  logic            m_read  [ND];
  logic            m_write [ND];
  logic [MW-1:0]   m_wmask [ND];
  logic [AW-1:0]   m_addr  [ND];
  logic [DW-1:0]   m_wdata [ND];
  logic            m_resp  [ND];
  logic [DW-1:0]   m_rdata [ND];
  logic            d_busy  [ND];
  logic [1:0]      d_gnt   [ND];

  // Instance 0 is round-robin, instance 1 is fixed priority.
  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    mem_port_arbiter #(
      .NUM_PORTS  (N),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .RR_MODE    ((gi == 0) ? 1 : 0)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .port_read    (p_read[gi]),
      .port_write   (p_write[gi]),
      .port_wmask   (p_wmask[gi]),
      .port_address (p_addr[gi]),
      .port_wdata   (p_wdata[gi]),
      .port_resp    (p_resp[gi]),
      .port_rdata   (p_rdata[gi]),
      .mem_read     (m_read[gi]),
      .mem_write    (m_write[gi]),
      .mem_wmask    (m_wmask[gi]),
      .mem_address  (m_addr[gi]),
      .mem_wdata    (m_wdata[gi]),
      .mem_resp     (m_resp[gi]),
      .mem_rdata    (m_rdata[gi]),
      .busy         (d_busy[gi]),
      .gnt_idx      (d_gnt[gi])
    );
  end

  int sel;
  int n_tests, n_fail;
  int cyc;

  // Requester behaviour per port.
  int            rq_mode  [N];
  bit            rq_act   [N];
  bit            rq_rd    [N];
  bit            rq_wr    [N];
  logic [AW-1:0] rq_addr  [N];
  logic [DW-1:0] rq_wdata [N];
  logic [MW-1:0] rq_mask  [N];
  int            rq_gap   [N];
  int            done_cnt [N];
  int            obs_cnt  [N];

  // Transaction-level reference: who owns the memory port, and for how long.
  bit ref_busy;
  int ref_gnt, ref_last, ref_age, ref_lat;
  int lat_cfg;
  bit stray_en, force_resp;
  logic [DW-1:0] mem_img [16];

  logic          o_read, o_write, o_busy;
  logic [N-1:0]  o_resp;
  logic [DW-1:0] o_rdata;
  logic [AW-1:0] o_addr;
  logic [MW-1:0] o_mask;
  int resp_log[$];
  int resp_cyc[$];
  int rd_seen, wr_seen, wr200_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: dut%0d cyc %0d got 0x%0h expected 0x%0h", tag, sel, cyc, got, exp);
    end
  endtask

  // Spec rule: search from last+1 (round-robin) or from 0, wrapping modulo N.
  function automatic int pick(input logic [N-1:0] req, input int last, input bit rr);
    int start;
    start = rr ? (last + 1) % N : 0;
    for (int k = 0; k < N; k++) begin
      if (req[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic set_txn(input int p, input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [MW-1:0] m, input int mode);
    rq_act[p] = 1'b1; rq_rd[p] = rd; rq_wr[p] = wr;
    rq_addr[p] = a; rq_wdata[p] = d; rq_mask[p] = m; rq_mode[p] = mode;
  endtask

  task automatic new_txn(input int p);
    int kind;
    kind = $urandom_range(0, 3);
    rq_act[p]   = 1'b1;
    rq_rd[p]    = (kind != 1);
    rq_wr[p]    = (kind == 1) || (kind == 2);
    rq_addr[p]  = AW'($urandom_range(0, 15) << 2);
    rq_wdata[p] = DW'($urandom);
    rq_mask[p]  = MW'($urandom);
  endtask

  task automatic complete(input int p);
    done_cnt[p]++;
    case (rq_mode[p])
      RQ_CONT: new_txn(p);
      RQ_RAND: begin rq_act[p] = 1'b0; rq_gap[p] = $urandom_range(0, 3); end
      default: begin rq_act[p] = 1'b0; rq_mode[p] = RQ_OFF; end
    endcase
  endtask

  task automatic drive_ports();
    for (int d = 0; d < ND; d++) begin
      p_read[d] = '0; p_write[d] = '0; m_resp[d] = 1'b0;
    end
    for (int p = 0; p < N; p++) begin
      p_read[sel][p]           = rq_act[p] & rq_rd[p];
      p_write[sel][p]          = rq_act[p] & rq_wr[p];
      p_addr[sel][p*AW +: AW]  = rq_addr[p];
      p_wdata[sel][p*DW +: DW] = rq_wdata[p];
      p_wmask[sel][p*MW +: MW] = rq_mask[p];
    end
  endtask

  task automatic step();
    logic [N-1:0]  req, exp_resp;
    logic          mresp;
    logic [DW-1:0] mdata;
    int w, idx, wn;
    @(negedge clk);
    drive_ports();
    w     = ref_gnt;
    idx   = int'(rq_addr[w][5:2]);
    mresp = 1'b0;
    mdata = DW'($urandom);
    if (ref_busy && (ref_age == ref_lat)) begin
      mresp = 1'b1;
      if (!rq_wr[w]) mdata = mem_img[idx];
    end else if (!ref_busy && (force_resp || (stray_en && ($urandom_range(0, 7) == 0)))) begin
      mresp = 1'b1;
    end
    force_resp   = 1'b0;
    m_resp[sel]  = mresp;
    m_rdata[sel] = mdata;
    #1;
    o_read = m_read[sel]; o_write = m_write[sel]; o_busy = d_busy[sel];
    o_resp = p_resp[sel]; o_rdata = p_rdata[sel]; o_addr = m_addr[sel]; o_mask = m_wmask[sel];

    check("busy", 64'(o_busy), 64'(ref_busy));
    check("gnt_idx", 64'(d_gnt[sel]), 64'(ref_gnt));
    check("mem_read", 64'(o_read), 64'(ref_busy & rq_rd[w] & ~rq_wr[w]));
    check("mem_write", 64'(o_write), 64'(ref_busy & rq_wr[w]));
    exp_resp = (ref_busy && mresp) ? (N'(1) << w) : '0;
    check("port_resp", 64'(o_resp), 64'(exp_resp));
    if (ref_busy) begin
      check("mem_address", 64'(o_addr), 64'(rq_addr[w]));
      if (rq_wr[w]) begin
        check("mem_wdata", 64'(m_wdata[sel]), 64'(rq_wdata[w]));
        check("mem_wmask", 64'(o_mask), 64'(rq_mask[w]));
      end else if (mresp) begin
        check("port_rdata", 64'(o_rdata), 64'(mem_img[idx]));
      end
    end

    if (o_read) rd_seen++;
    if (o_write) wr_seen++;
    if (o_write && mresp && (o_addr == 32'h200) && (o_mask == 4'b0011)) wr200_seen++;
    for (int p = 0; p < N; p++) begin
      if (o_resp[p]) begin
        obs_cnt[p]++;
        resp_log.push_back(p);
        resp_cyc.push_back(cyc);
        $display("[TB] dut%0d cyc %0d port %0d %s addr=%08h wdata=%08h mask=%h rdata=%08h",
                 sel, cyc, p, o_write ? "WR" : "RD", o_addr, m_wdata[sel], o_mask, o_rdata);
      end
    end

    if (ref_busy) begin
      if (mresp) begin
        if (rq_wr[w]) begin
          for (int b = 0; b < MW; b++)
            if (rq_mask[w][b]) mem_img[idx][8*b +: 8] = rq_wdata[w][8*b +: 8];
        end
        complete(w);
        ref_busy = 1'b0;
      end else begin
        ref_age++;
      end
    end else begin
      for (int p = 0; p < N; p++) req[p] = rq_act[p];
      wn = pick(req, ref_last, sel == 0);
      if (wn >= 0) begin
        ref_busy = 1'b1; ref_gnt = wn; ref_last = wn; ref_age = 0;
        ref_lat  = (lat_cfg >= 0) ? lat_cfg : $urandom_range(0, 3);
      end
    end
    for (int p = 0; p < N; p++) begin
      if ((rq_mode[p] == RQ_RAND) && !rq_act[p]) begin
        if (rq_gap[p] > 0) rq_gap[p]--;
        else if ($urandom_range(0, 2) == 0) new_txn(p);
      end
    end
    cyc++;
  endtask

  // Asserts reset mid-cycle and checks its asynchronous effect before the next edge.
  task automatic apply_reset(input int which);
    sel = which;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy", 64'(d_busy[sel]), 64'(0));
    check("rst_mem_req", 64'({m_read[sel], m_write[sel]}), 64'(0));
    check("rst_addr_known", 64'($isunknown(m_addr[sel])), 64'(0));
    for (int p = 0; p < N; p++) begin
      rq_act[p] = 1'b0; rq_mode[p] = RQ_OFF; rq_gap[p] = 0;
      done_cnt[p] = 0; obs_cnt[p] = 0;
    end
    ref_busy = 1'b0; ref_gnt = 0; ref_last = N - 1; ref_age = 0; ref_lat = 0;
    drive_ports();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    resp_log.delete();
    resp_cyc.delete();
    rd_seen = 0; wr_seen = 0; wr200_seen = 0;
  endtask

  initial begin
    int total;
    n_tests = 0; n_fail = 0; cyc = 0; sel = 0;
    stray_en = 1'b0; force_resp = 1'b0; lat_cfg = 3;
    for (int d = 0; d < ND; d++) begin
      p_read[d] = '0; p_write[d] = '0; p_wmask[d] = '0; p_addr[d] = '0; p_wdata[d] = '0;
      m_resp[d] = 1'b0; m_rdata[d] = '0;
    end
    for (int p = 0; p < N; p++) begin
      rq_act[p] = 1'b0; rq_rd[p] = 1'b0; rq_wr[p] = 1'b0; rq_addr[p] = '0;
      rq_wdata[p] = '0; rq_mask[p] = '0; rq_mode[p] = RQ_OFF; rq_gap[p] = 0;
    end
    for (int i = 0; i < 16; i++) mem_img[i] = 32'h1000_0000 + 32'(i);

    // Single read, latency 3: request c0, mem_read c1, resp c4, idle c5.
    apply_reset(0);
    lat_cfg = 3;
    mem_img[0] = 32'hDEADBEEF;
    set_txn(0, 1'b1, 1'b0, 32'h100, '0, '0, RQ_ONESHOT);
    step(); check("t1_read_c0", 64'(o_read), 64'(0));
    step(); check("t1_read_c1", 64'(o_read), 64'(1));
    step(); step(); check("t1_resp_c3", 64'(o_resp), 64'(0));
    step(); check("t1_resp_c4", 64'(o_resp), 64'(4'b0001));
    check("t1_rdata_c4", 64'(o_rdata), 64'(32'hDEADBEEF));
    step(); check("t1_busy_c5", 64'(o_busy), 64'(0));

    // Round-robin with all ports requesting continuously.
    apply_reset(0);
    lat_cfg = 2;
    for (int p = 0; p < N; p++) begin new_txn(p); rq_mode[p] = RQ_CONT; end
    for (int i = 0; (i < 100) && (resp_log.size() < 5); i++) step();
    check("t2_count", 64'(resp_log.size() >= 5), 64'(1));
    for (int i = 0; i < 5; i++) check("t2_order", 64'(resp_log[i]), 64'(i % N));
    for (int i = 1; i < 5; i++) check("t2_period", 64'(resp_cyc[i] - resp_cyc[i-1]), 64'(2 + 2));

    // Fixed priority: port 1 keeps winning, port 2 starves.
    apply_reset(1);
    lat_cfg = 1;
    new_txn(1); rq_mode[1] = RQ_CONT;
    new_txn(2); rq_mode[2] = RQ_CONT;
    repeat (30) step();
    check("t3_count", 64'(resp_log.size() >= 5), 64'(1));
    foreach (resp_log[i]) check("t3_winner", 64'(resp_log[i]), 64'(1));
    check("t3_port2_starved", 64'(obs_cnt[2]), 64'(0));

    // Simultaneous read on port 0 and masked write on port 1.
    apply_reset(0);
    lat_cfg = 2;
    set_txn(1, 1'b0, 1'b1, 32'h200, 32'hA5A5A5A5, 4'b0011, RQ_ONESHOT);
    set_txn(0, 1'b1, 1'b0, 32'h300, '0, '0, RQ_ONESHOT);
    repeat (20) step();
    check("t4_resp_total", 64'(resp_log.size()), 64'(2));
    check("t4_first", 64'(resp_log[0]), 64'(0));
    check("t4_second", 64'(resp_log[1]), 64'(1));
    check("t4_write_once", 64'(wr200_seen), 64'(1));

    // Reset in BUSY, stray mem_resp right after, then a normal grant.
    apply_reset(0);
    lat_cfg = 6;
    set_txn(2, 1'b1, 1'b0, 32'h40, '0, '0, RQ_ONESHOT);
    repeat (3) step();
    check("t5_busy_before", 64'(o_busy), 64'(1));
    apply_reset(0);
    force_resp = 1'b1;
    step();
    check("t5_no_resp", 64'(o_resp), 64'(0));
    check("t5_idle", 64'(o_busy), 64'(0));
    lat_cfg = 1;
    set_txn(3, 1'b1, 1'b0, 32'h44, '0, '0, RQ_ONESHOT);
    repeat (6) step();
    check("t5_resp_total", 64'(resp_log.size()), 64'(1));
    check("t5_port", 64'(resp_log[0]), 64'(3));

    // Read and write together on one port go downstream as a write only.
    apply_reset(1);
    lat_cfg = 2;
    set_txn(3, 1'b1, 1'b1, 32'h80, 32'h12345678, 4'hF, RQ_ONESHOT);
    repeat (8) step();
    check("t6_no_read", 64'(rd_seen), 64'(0));
    check("t6_write_cycles", 64'(wr_seen), 64'(3));
    check("t6_resp_total", 64'(resp_log.size()), 64'(1));

    // Random traffic with random latency and stray responses on both arbiters.
    for (int d = 0; d < ND; d++) begin
      apply_reset(d);
      stray_en = 1'b1;
      lat_cfg  = -1;
      for (int p = 0; p < N; p++) begin
        rq_mode[p] = RQ_RAND; rq_gap[p] = $urandom_range(0, 3);
      end
      repeat (400) step();
      total = 0;
      for (int p = 0; p < N; p++) total += done_cnt[p];
      check("rand_resp_total", 64'(resp_log.size()), 64'(total));
      check("rand_progress", 64'(total > 20), 64'(1));
      stray_en = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
